// File: rtl/ihadamard4x4_pu.sv
// Inverse 4x4 Hadamard PU: per-row horizontal butterfly on input, then vertical butterfly + /16 rounding on output.
// Optional IHT_SAT_EN saturates residuals to RES_W; otherwise the rounded value wraps to its low RES_W bits.
module ihadamard4x4_pu #(
  parameter int COEF_W = 16,
  parameter int RES_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_c0,
  input  logic [COEF_W-1:0] in_c1,
  input  logic [COEF_W-1:0] in_c2,
  input  logic [COEF_W-1:0] in_c3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_r0,
  output logic [RES_W-1:0]  out_r1,
  output logic [RES_W-1:0]  out_r2,
  output logic [RES_W-1:0]  out_r3,
  output logic [1:0]        out_row,
  output logic              out_last
);

  localparam int TW = COEF_W + 2;
`ifdef IHT_SAT_EN
  localparam int AW = COEF_W + 4;
`else
  // Wrapping output only needs the low RES_W+4 bits of the column sum.
  localparam int AW = RES_W + 4;
`endif
  localparam int RW = AW - 4;

  typedef enum logic {ST_LOAD, ST_OUT} state_t;

  state_t     state, state_nxt;
  logic [1:0] ld_cnt, ld_cnt_nxt, out_row_nxt;
  logic       wr;

  logic signed [TW-1:0] a, b, c, d;
  logic signed [TW-1:0] p    [4];
  logic signed [TW-1:0] tbuf [4][4];

  logic [3:0]           neg;
  logic signed [AW-1:0] acc  [4];
  logic signed [AW-1:0] bias [4];
  logic signed [RW-1:0] rnd  [4];
  logic [RES_W-1:0]     res  [4];
  logic                 unused_lo;

  // Row pass
  always_comb begin
    a    = TW'($signed(in_c0));
    b    = TW'($signed(in_c1));
    c    = TW'($signed(in_c2));
    d    = TW'($signed(in_c3));
    p[0] = a + b + c + d;
    p[1] = a + b - c - d;
    p[2] = a - b - c + d;
    p[3] = a - b + c - d;
  end

  assign wr = in_valid & in_ready & ~clear;

  always_ff @(posedge clk) begin
    if (wr) begin
      for (int j = 0; j < 4; j++) tbuf[ld_cnt][j] <= p[j];
    end
  end

  // Negative entries of H row r (bit k set means H[r][k] = -1)
  always_comb begin
    case (out_row)
      2'd0:    neg = 4'b0000;
      2'd1:    neg = 4'b1100;
      2'd2:    neg = 4'b0110;
      default: neg = 4'b1010;
    endcase
  end

  // Column pass, rounding and narrowing
  always_comb begin
    unused_lo = 1'b0;
    for (int j = 0; j < 4; j++) begin
      acc[j] = '0;
      for (int k = 0; k < 4; k++) begin
        if (neg[k]) acc[j] = acc[j] - AW'(tbuf[k][j]);
        else        acc[j] = acc[j] + AW'(tbuf[k][j]);
      end
      bias[j]   = acc[j] + AW'(8);
      rnd[j]    = bias[j][AW-1:4];
      unused_lo = unused_lo ^ (^bias[j][3:0]);
`ifdef IHT_SAT_EN
      if ((&rnd[j][RW-1:RES_W-1]) || !(|rnd[j][RW-1:RES_W-1]))
        res[j] = rnd[j][RES_W-1:0];
      else if (rnd[j][RW-1])
        res[j] = {1'b1, {(RES_W-1){1'b0}}};
      else
        res[j] = {1'b0, {(RES_W-1){1'b1}}};
`else
      res[j] = rnd[j][RES_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_LOAD;
      ld_cnt  <= 2'd0;
      out_row <= 2'd0;
    end else begin
      state   <= state_nxt;
      ld_cnt  <= ld_cnt_nxt;
      out_row <= out_row_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ld_cnt_nxt  = ld_cnt;
    out_row_nxt = out_row;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_cnt_nxt = ld_cnt + 2'd1;
          if (ld_cnt == 2'd3) state_nxt = ST_OUT;
        end
      end
      default: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_row_nxt = out_row + 2'd1;
          if (out_row == 2'd3) state_nxt = ST_LOAD;
        end
      end
    endcase
    // Abort wins over any handshake in the same cycle.
    if (clear) begin
      state_nxt   = ST_LOAD;
      ld_cnt_nxt  = 2'd0;
      out_row_nxt = 2'd0;
    end
  end

  assign out_r0   = out_valid ? res[0] : '0;
  assign out_r1   = out_valid ? res[1] : '0;
  assign out_r2   = out_valid ? res[2] : '0;
  assign out_r3   = out_valid ? res[3] : '0;
  assign out_last = out_valid & (out_row == 2'd3);

endmodule

// File: tb/tb_ihadamard4x4_pu.sv
// Bench for ihadamard4x4_pu: scoreboard of expected rows from a direct H*C*H/16 matrix model.
module tb_ihadamard4x4_pu;
  localparam int COEF_W = 16;
  localparam int RES_W  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_last;
  logic [COEF_W-1:0] in_c0 = '0, in_c1 = '0, in_c2 = '0, in_c3 = '0;
  logic [RES_W-1:0] out_r0, out_r1, out_r2, out_r3;
  logic [1:0] out_row;

  typedef struct packed {
    logic [RES_W-1:0] r0, r1, r2, r3;
    logic [1:0]       row;
    logic             last;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   blk [16];
  exp_t sb [$];
  exp_t mon_e;
  bit   stim_done;

  ihadamard4x4_pu #(.COEF_W(COEF_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2), .in_c3(in_c3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r0(out_r0), .out_r1(out_r1), .out_r2(out_r2), .out_r3(out_r3),
    .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic int hv(int r, int k);
    case (r)
      0:       return 1;
      1:       return (k < 2) ? 1 : -1;
      2:       return (k == 0 || k == 3) ? 1 : -1;
      default: return (k == 0 || k == 2) ? 1 : -1;
    endcase
  endfunction

  function automatic logic [RES_W-1:0] model(int r, int j);
    int s = 0;
    int y;
    for (int k = 0; k < 4; k++)
      for (int m = 0; m < 4; m++)
        s += hv(r, k) * blk[k*4+m] * hv(m, j);
    y = (s + 8) >>> 4;
`ifdef IHT_SAT_EN
    if (y > 511)  y = 511;
    if (y < -512) y = -512;
`endif
    return y[RES_W-1:0];
  endfunction

  task automatic set_dc(int v);
    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[0] = v;
  endtask

  task automatic push_block();
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      e.r0 = model(r, 0); e.r1 = model(r, 1);
      e.r2 = model(r, 2); e.r3 = model(r, 3);
      e.row = 2'(r);
      e.last = (r == 3);
      sb.push_back(e);
    end
  endtask

  task automatic send_row(int k);
    int i;
    for (i = 0; i < 200 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_c0 = 16'(blk[k*4+0]); in_c1 = 16'(blk[k*4+1]);
    in_c2 = 16'(blk[k*4+2]); in_c3 = 16'(blk[k*4+3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(bit push);
    if (push) push_block();
    for (int k = 0; k < 4; k++) send_row(k);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && !(sb.size() == 0 && in_ready); i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (!(sb.size() == 0 && in_ready)) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%0b required 0/1", sb.size(), in_ready);
    end
  endtask

  // Scoreboard: compare every output handshake against the next expected row.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_row: row=%0d with empty scoreboard", out_row);
      end else begin
        mon_e = sb.pop_front();
        if ({out_r0, out_r1, out_r2, out_r3, out_row, out_last} !== mon_e) begin
          errors++;
          $display("FAIL row_data: got r=%0d,%0d,%0d,%0d row=%0d last=%0b required r=%0d,%0d,%0d,%0d row=%0d last=%0b",
                   $signed(out_r0), $signed(out_r1), $signed(out_r2), $signed(out_r3), out_row, out_last,
                   $signed(mon_e.r0), $signed(mon_e.r1), $signed(mon_e.r2), $signed(mon_e.r3), mon_e.row, mon_e.last);
        end
      end
    end
  end

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, out_row, out_last, out_r0} !== {1'b1, 1'b0, 2'd0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b row=%0d last=%0b r0=%0d required 1 0 0 0 0",
               in_ready, out_valid, out_row, out_last, out_r0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dc();
    out_ready = 1'b1;
    set_dc(16);
    send_block(1'b1);
    checks++;
    if ({out_valid, out_row, out_r0} !== {1'b1, 2'd0, 10'd1}) begin
      errors++;
      $display("FAIL dc_latency: vld=%0b row=%0d r0=%0d required 1 0 1", out_valid, out_row, out_r0);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({out_last, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL dc_last: last=%0b rdy=%0b required 1 0", out_last, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, out_r0} !== {1'b1, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL dc_return: rdy=%0b vld=%0b r0=%0d required 1 0 0", in_ready, out_valid, out_r0);
    end
    wait_drain();
  endtask

  task automatic test_patterns();
    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[1] = 16;
    send_block(1'b1);
    set_dc(80);
    send_block(1'b1);
    set_dc(-24);
    send_block(1'b1);
    for (int i = 0; i < 16; i++) blk[i] = (i * 37 % 23) - 11;
    send_block(1'b1);
    wait_drain();
  endtask

  task automatic test_overflow();
    logic [RES_W-1:0] ovf_exp;
`ifdef IHT_SAT_EN
    ovf_exp = 10'd511;
`else
    ovf_exp = 10'(-424);
`endif
    out_ready = 1'b0;
    set_dc(9600);
    send_block(1'b1);
    checks++;
    if (out_r2 !== ovf_exp) begin
      errors++;
      $display("FAIL overflow: r2=%0d required %0d", $signed(out_r2), $signed(ovf_exp));
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) blk[i] = $urandom_range(0, 800) - 400;
    out_ready = 1'b1;
    send_block(1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_row, out_r0, out_r1, out_r2, out_r3} !==
          {1'b1, 1'b0, 2'd1, sb[0].r0, sb[0].r1, sb[0].r2, sb[0].r3}) begin
        errors++;
        $display("FAIL bp_hold: vld=%0b rdy=%0b row=%0d r0=%0d required 1 0 1 r0=%0d",
                 out_valid, in_ready, out_row, $signed(out_r0), $signed(sb[0].r0));
      end
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 16; i++) blk[i] = 100 + i;
    send_row(0);
    send_row(1);
    clear = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL clear_load: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
    set_dc(32);
    send_block(1'b1);
    wait_drain();
    // abort while presenting output
    out_ready = 1'b0;
    set_dc(48);
    send_block(1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if ({out_valid, out_row, in_ready, out_r0} !== {1'b0, 2'd0, 1'b1, 10'd0}) begin
      errors++;
      $display("FAIL clear_out: vld=%0b row=%0d rdy=%0b r0=%0d required 0 0 1 0",
               out_valid, out_row, in_ready, out_r0);
    end
    out_ready = 1'b1;
    set_dc(-40);
    send_block(1'b1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    set_dc(64);
    send_block(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_row} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid_out: vld=%0b rdy=%0b row=%0d required 0 1 0", out_valid, in_ready, out_row);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 7 * i - 50;
    send_row(0);
    send_row(1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 300 - 13 * i;
    send_block(1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    stim_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          for (int i = 0; i < 16; i++) blk[i] = $urandom_range(0, 4000) - 2000;
          send_block(1'b1);
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_dc();
    test_patterns();
    test_overflow();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
